// File: rtl/icache_direct.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Hits return one cycle after the request; misses hold mem_req until the
// memory controller answers, then fill the line and forward the word.
module icache_direct #(
    parameter int INDEX_BITS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        fetch_valid,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_done,
    input  logic [31:0] mem_inst,
    input  logic        jump_flag
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int TAG_W = 30 - INDEX_BITS;

    // Word address split into tag and line index.
    typedef struct packed {
        logic [TAG_W-1:0]      tag;
        logic [INDEX_BITS-1:0] idx;
    } waddr_t;

    typedef enum logic { IDLE, MISS } state_t;

    state_t             state;
    logic [LINES-1:0]   valid_q;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    waddr_t req_a;
    waddr_t fill_a;
    logic   hit;
    logic   fill_en;
    logic   unused_bits;

    // The miss address register doubles as the latched request, so the
    // fill line is decoded straight from mem_addr.
    assign req_a       = waddr_t'(fetch_pc[31:2]);
    assign fill_a      = waddr_t'(mem_addr[31:2]);
    assign hit         = valid_q[req_a.idx] && (tag_mem[req_a.idx] == req_a.tag);
    assign fill_en     = rdy && (state == MISS) && mem_done;
    assign unused_bits = ^fetch_pc[1:0];

    // Tag/data storage: not reset, written only when a miss is answered
    // (even if a jump arrives in the same cycle, the word is still correct).
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[fill_a.idx]  <= fill_a.tag;
            data_mem[fill_a.idx] <= mem_inst;
        end
    end

    // Control FSM, valid bits and registered fetch/memory outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            valid_q     <= '0;
            fetch_ready <= 1'b0;
            fetch_inst  <= '0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else if (!rdy) begin
            fetch_ready <= 1'b0;
        end else begin
            fetch_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (fetch_valid && !jump_flag) begin
                        if (hit) begin
                            fetch_inst  <= data_mem[req_a.idx];
                            fetch_ready <= 1'b1;
                        end else begin
                            mem_addr <= {fetch_pc[31:2], 2'b00};
                            mem_req  <= 1'b1;
                            state    <= MISS;
                        end
                    end
                end
                MISS: begin
                    if (mem_done) begin
                        valid_q[fill_a.idx] <= 1'b1;
                        if (!jump_flag) begin
                            fetch_inst  <= mem_inst;
                            fetch_ready <= 1'b1;
                        end
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end else if (jump_flag) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: cold miss, hit, conflict, jump abort,
// jump coincident with fill, rdy freeze and asynchronous reset mid-miss.
module tb_icache_direct;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_pc = '0;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done = 1'b0;
    logic [31:0] mem_inst = '0;
    logic        jump_flag = 1'b0;

    int checks = 0;
    int failures = 0;

    icache_direct #(.INDEX_BITS(8)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_ready(fetch_ready), .fetch_inst(fetch_inst),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_done(mem_done), .mem_inst(mem_inst),
        .jump_flag(jump_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next one.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic req(input logic [31:0] pc);
        fetch_valid = 1'b1;
        fetch_pc    = pc;
        step();
        fetch_valid = 1'b0;
    endtask

    task automatic done(input logic [31:0] d);
        mem_done = 1'b1;
        mem_inst = d;
        step();
        mem_done = 1'b0;
    endtask

    initial begin
        repeat (2) step();
        chk("rst_ready", {31'd0, fetch_ready}, 32'd0);
        chk("rst_inst",  fetch_inst, 32'd0);
        chk("rst_req",   {31'd0, mem_req}, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        rst = 1'b1;
        step();

        // cold miss on 0x0
        req(32'h0);
        chk("cold_req",   {31'd0, mem_req}, 32'd1);
        chk("cold_addr",  mem_addr, 32'h0);
        chk("cold_noack", {31'd0, fetch_ready}, 32'd0);
        repeat (4) step();
        chk("cold_hold",  {31'd0, mem_req}, 32'd1);
        done(32'h00000013);
        chk("cold_ready", {31'd0, fetch_ready}, 32'd1);
        chk("cold_inst",  fetch_inst, 32'h00000013);
        chk("cold_reqlo", {31'd0, mem_req}, 32'd0);
        step();
        chk("pulse_end",  {31'd0, fetch_ready}, 32'd0);

        // hit on 0x0 (low pc bits ignored)
        req(32'h3);
        chk("hit_ready", {31'd0, fetch_ready}, 32'd1);
        chk("hit_inst",  fetch_inst, 32'h00000013);
        chk("hit_noreq", {31'd0, mem_req}, 32'd0);

        // conflict: 0x400 shares index 0
        req(32'h400);
        chk("conf_req",  {31'd0, mem_req}, 32'd1);
        chk("conf_addr", mem_addr, 32'h400);
        done(32'hDEADBEEF);
        chk("conf_inst", fetch_inst, 32'hDEADBEEF);
        req(32'h0);
        chk("conf0_req",  {31'd0, mem_req}, 32'd1);
        chk("conf0_addr", mem_addr, 32'h0);
        done(32'h00000013);
        req(32'h400);
        chk("conf4_req",  {31'd0, mem_req}, 32'd1);
        chk("conf4_addr", mem_addr, 32'h400);
        done(32'hDEADBEEF);

        // jump during miss
        req(32'h1004);
        chk("jmp_req", {31'd0, mem_req}, 32'd1);
        step();
        jump_flag = 1'b1;
        step();
        jump_flag = 1'b0;
        chk("jmp_reqlo", {31'd0, mem_req}, 32'd0);
        chk("jmp_noack", {31'd0, fetch_ready}, 32'd0);
        done(32'h00000BAD);
        chk("late_done_ack", {31'd0, fetch_ready}, 32'd0);
        chk("late_done_req", {31'd0, mem_req}, 32'd0);
        req(32'h1004);
        chk("jmp_remiss", {31'd0, mem_req}, 32'd1);
        chk("jmp_readdr", mem_addr, 32'h1004);
        done(32'h11112222);
        chk("jmp_fill", fetch_inst, 32'h11112222);

        // jump coincident with mem_done: fill but no response
        req(32'h2008);
        chk("co_req", {31'd0, mem_req}, 32'd1);
        step();
        jump_flag = 1'b1;
        done(32'h00100093);
        jump_flag = 1'b0;
        chk("co_noack", {31'd0, fetch_ready}, 32'd0);
        chk("co_reqlo", {31'd0, mem_req}, 32'd0);
        req(32'h2008);
        chk("co_hit",   {31'd0, fetch_ready}, 32'd1);
        chk("co_inst",  fetch_inst, 32'h00100093);
        chk("co_noreq", {31'd0, mem_req}, 32'd0);

        // refill 0x0 so it hits before the reset test
        req(32'h0);
        done(32'h00000013);
        req(32'h0);
        chk("pre_rst_hit", {31'd0, fetch_ready}, 32'd1);

        // rdy freeze during a miss
        req(32'h3010);
        chk("rdy_req", {31'd0, mem_req}, 32'd1);
        rdy = 1'b0;
        done(32'h55555555);
        chk("rdy_ack",  {31'd0, fetch_ready}, 32'd0);
        chk("rdy_req1", {31'd0, mem_req}, 32'd1);
        chk("rdy_addr", mem_addr, 32'h3010);
        step();
        rdy = 1'b1;
        step();
        chk("rdy_hold", {31'd0, mem_req}, 32'd1);
        chk("rdy_ack2", {31'd0, fetch_ready}, 32'd0);
        jump_flag = 1'b1;
        step();
        jump_flag = 1'b0;
        req(32'h3010);
        chk("rdy_nofill", {31'd0, mem_req}, 32'd1);

        // asynchronous reset mid-miss
        rst = 1'b0;
        #1;
        chk("arst_req",  {31'd0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_inst", fetch_inst, 32'd0);
        chk("arst_ack",  {31'd0, fetch_ready}, 32'd0);
        @(negedge clk);
        step();
        rst = 1'b1;
        step();
        req(32'h0);
        chk("post_rst_miss", {31'd0, mem_req}, 32'd1);
        chk("post_rst_ack",  {31'd0, fetch_ready}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
